// File: rtl/bin_to_bcd_if.sv
// bin_to_bcd_seq_if: start/busy/done handshake plus data for the
// sequential binary-to-BCD converter.
//   start   - request a conversion (master -> slave)
//   bin_in  - binary value, WIDTH bits (master -> slave)
//   busy    - conversion in progress (slave -> master)
//   done    - one-cycle result-valid pulse (slave -> master)
//   bcd_out - packed BCD digits, ones in [3:0] (slave -> master)
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (output start, output bin_in, input busy, input done, input bcd_out);
  modport slave  (input start, input bin_in, output busy, output done, output bcd_out);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one
// input bit per clock. A conversion takes WIDTH+2 cycles from acceptance
// to the next possible acceptance.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of bin_to_bcd_seq_if (start, bin_in, busy, done, bcd_out)
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  bin_to_bcd_seq_if.slave    bus
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   scratch;
  logic [WIDTH-1:0] bin_reg;
  logic [CW-1:0]   cnt;
  logic            busy_r;
  logic            done_r;
  logic [SW-1:0]   bcd_r;

  logic [SW-1:0]       adj;
  logic [SW+WIDTH-1:0] shifted;

  // Add-3 on every digit in parallel, then shift {scratch, bin_reg} left.
  // An adjusted digit is at most 12, so digits never carry into each other.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin_reg} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      scratch <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            bin_reg <= bus.bin_in;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[SW+WIDTH-1 -: SW];
          bin_reg <= shifted[WIDTH-1:0];
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bcd_r  <= shifted[SW+WIDTH-1 -: SW];
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.bcd_out = bcd_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq. Inputs are
// driven and outputs sampled on the falling clock edge; expected BCD values
// come from a decimal /10 %10 reference model.
module tb_bin_to_bcd_seq;
  localparam int W = 8;
  localparam int D = 3;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*D-1:0] ref_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Pulse start for one cycle with value v, then watch 14 sampled cycles.
  // Sample index i=1 is the falling edge right after the accepting edge.
  task automatic run_conv(input logic [W-1:0] v, output logic [4*D-1:0] res,
                          output int done_at, output int done_cnt, output int busy_cnt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = W'($urandom);
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    res      = '0;
    for (int i = 1; i <= 14; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i;
          res = bus.bcd_out;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.bcd_out} !== {1'b0, 1'b0, 12'h000}) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b bcd=%h, want 0 0 000",
               bus.busy, bus.done, bus.bcd_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] vals [8];
    logic [4*D-1:0] res;
    int at, dc, bc;
    vals[0] = 8'd0;   vals[1] = 8'd255; vals[2] = 8'd21; vals[3] = 8'd99;
    for (int k = 4; k < 8; k++) vals[k] = W'($urandom);
    for (int k = 0; k < 8; k++) begin
      run_conv(vals[k], res, at, dc, bc);
      checks++;
      if (res !== ref_bcd(int'(vals[k]))) begin
        errors++;
        $display("FAIL basic_value(%0d): got %h want %h", vals[k], res, ref_bcd(int'(vals[k])));
      end
      checks++;
      if (at !== 9 || dc !== 1) begin
        errors++;
        $display("FAIL basic_done_timing(%0d): done at %0d count %0d, want at 9 count 1",
                 vals[k], at, dc);
      end
      checks++;
      if (bc !== 9) begin
        errors++;
        $display("FAIL basic_busy_len(%0d): %0d cycles, want 9", vals[k], bc);
      end
      checks++;
      if (bus.bcd_out !== ref_bcd(int'(vals[k]))) begin
        errors++;
        $display("FAIL basic_hold(%0d): got %h want %h", vals[k], bus.bcd_out,
                 ref_bcd(int'(vals[k])));
      end
    end
  endtask

  // start held high; bin_in = 17+j ahead of edge E_j. Acceptances happen at
  // E0, E10, E20, E30, so results are 17, 27, 37 with done sampled at j=9,19,29.
  task automatic test_back_to_back();
    logic [4*D-1:0] last;
    int dones;
    last  = bus.bcd_out;
    dones = 0;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (j > 0) begin
        if ((j % 10) == 9) begin
          dones++;
          last = ref_bcd(17 + j - 9);
          checks++;
          if (bus.done !== 1'b1 || bus.bcd_out !== last) begin
            errors++;
            $display("FAIL b2b_result(j=%0d): done=%b bcd=%h, want 1 %h", j, bus.done,
                     bus.bcd_out, last);
          end
        end else begin
          checks++;
          if (bus.done !== 1'b0 || bus.bcd_out !== last) begin
            errors++;
            $display("FAIL b2b_stable(j=%0d): done=%b bcd=%h, want 0 %h", j, bus.done,
                     bus.bcd_out, last);
          end
        end
      end
      bus.start  = 1'b1;
      bus.bin_in = W'(17 + j);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (dones !== 3 || bus.bcd_out !== ref_bcd(47)) begin
      errors++;
      $display("FAIL b2b_drain: dones=%0d bcd=%h, want 3 %h", dones, bus.bcd_out, ref_bcd(47));
    end
  endtask

  task automatic test_ignore_start();
    int dc, at;
    logic [4*D-1:0] res;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 8'd42;
    @(negedge clk);
    bus.start  = 1'b0;
    dc = 0; at = -1; res = '0;
    for (int i = 1; i <= 24; i++) begin
      if (bus.done) begin
        dc++;
        if (at < 0) begin at = i; res = bus.bcd_out; end
      end
      if (i == 3) begin bus.start = 1'b1; bus.bin_in = 8'd200; end
      if (i == 4) bus.start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (res !== 12'h042 || at !== 9) begin
      errors++;
      $display("FAIL ignore_start_result: got %h at %0d, want 042 at 9", res, at);
    end
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL ignore_start_done_count: got %0d want 1", dc);
    end
  endtask

  task automatic test_async_reset();
    int dc, at, bc;
    logic [4*D-1:0] res;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 8'd150;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.bcd_out} !== {1'b0, 1'b0, 12'h000}) begin
      errors++;
      $display("FAIL async_reset_outputs: busy=%b done=%b bcd=%h, want 0 0 000",
               bus.busy, bus.done, bus.bcd_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0; bc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) dc++;
      if (bus.busy) bc++;
    end
    checks++;
    if (dc !== 0 || bc !== 0 || bus.bcd_out !== 12'h000) begin
      errors++;
      $display("FAIL async_reset_discard: dones=%0d busy=%0d bcd=%h, want 0 0 000",
               dc, bc, bus.bcd_out);
    end
    run_conv(8'd7, res, at, dc, bc);
    checks++;
    if (res !== 12'h007 || at !== 9 || dc !== 1) begin
      errors++;
      $display("FAIL async_reset_recover: got %h at %0d count %0d, want 007 at 9 count 1",
               res, at, dc);
    end
  endtask

  // Values held for 10 cycles each with start high, aligned to the
  // acceptance cadence; every result is collected from the done pulses.
  task automatic test_sweep();
    logic [4*D-1:0] got [$];
    for (int v = 0; v < 256; v++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bus.done) got.push_back(bus.bcd_out);
        bus.start  = 1'b1;
        bus.bin_in = W'(v);
      end
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.done) got.push_back(bus.bcd_out);
      bus.start = 1'b0;
    end
    checks++;
    if (got.size() !== 256) begin
      errors++;
      $display("FAIL sweep_done_count: got %0d want 256", got.size());
    end
    for (int k = 0; k < 256 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== ref_bcd(k)) begin
        errors++;
        $display("FAIL sweep_value(%0d): got %h want %h", k, got[k], ref_bcd(k));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter. It uses the shift-and-add-3 (double-dabble) method, one bit per clock. It sits upstream of the per-digit segment decoders and turns binary scores and card totals into packed BCD digits. Each 4-bit digit of its output feeds one segment decoder. A start/busy/done handshake lets the game controller launch a conversion and pick up the result.

## Interface
- WIDTH, 8: width of the binary input.
- DIGITS, 3: number of BCD digits produced. Legal only if 2^WIDTH-1 <= 10^DIGITS-1; any other configuration is unsupported.
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset; one clock, asynchronous and active-low.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  WIDTH  binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress (SHIFT and DONE states).
- done  output  1  one-cycle pulse; bcd_out holds the new result in the same cycle.
- bcd_out  output  4*DIGITS  packed BCD result. Digit 0 (ones) is in [3:0], digit 1 (tens) in [7:4], and so on. Held until the next done.

## Operation
- State machine: IDLE, SHIFT, DONE. All outputs and state are registered.
- IDLE:
  - busy=0, done=0.
  - On start=1: bin_reg<=bin_in, scratch<=0, cnt<=WIDTH, go to SHIFT.
- SHIFT, once per cycle:
  - For each 4-bit scratch digit >= 5, add 3 to that digit.
  - Then shift {scratch, bin_reg} left by 1 and decrement cnt.
  - When cnt==1, the shift in that edge is the last one. The post-shift scratch value loads into bcd_out on the same edge, and the state goes to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditionally to IDLE.
- Add-3 rule:
  - Applied to every digit in parallel before the shift, within the same cycle.
  - Each digit is computed in 4 bits; after adjustment a digit never exceeds 4'd12, so there is no carry between digits.
- Input handling:
  - start is ignored in SHIFT and DONE.
  - bin_in changes after capture have no effect.
  - start held high continuously gives back-to-back conversions, each accepted on the first IDLE cycle.
- bcd_out changes only on the edge that enters DONE. Between conversions it holds the previous result.
- Reset (rst_n=0, at any time including mid-conversion):
  - state=IDLE, busy=0, done=0, bcd_out=0, scratch=0, bin_reg=0, cnt=0.
  - A conversion in flight is discarded and no done is produced.
  - After rst_n rises, the first rising edge with start=1 is accepted normally.
- Values 0 and 2^WIDTH-1 need no special handling.

## Timing
- Edge E0 accepts start. busy rises after E0.
- Shifts occur on edges E1..E_WIDTH. bcd_out loads and done rises after edge E_WIDTH.
- done is high during the cycle between E_WIDTH and E_WIDTH+1. This is WIDTH cycles after busy rose; 8 for the defaults.
- busy and done fall after E_WIDTH+1; the FSM is back in IDLE.
- The earliest next acceptance is E_WIDTH+2.
- Throughput is one conversion per WIDTH+2 cycles (10 for the defaults).
- No combinational path from any input to any output.

## Test plan
- Reset, then bin_in=0 with start pulsed at E0 -> bcd_out=12'h000; done high exactly in the cycle after E8; busy high for 9 cycles.
- bin_in=8'd255 -> bcd_out=12'h255. bin_in=8'd21 -> 12'h021. bin_in=8'd99 -> 12'h099. Each done is a single-cycle pulse.
- start held at 1, with bin_in stepped every cycle from 17 to 18 to 19 -> conversions accepted every 10 cycles. Each result equals the bin_in present on its acceptance edge; bcd_out is stable between dones.
- Pulse start=1 with bin_in=200 at E3 during a busy conversion of 42 -> ignored. Result is 12'h042 and no second done follows.
- rst_n low for 1 cycle at E4 of a conversion of 150 -> busy, done and bcd_out are 0 immediately (asynchronous) and no done appears. A new conversion of 7 after release yields 12'h007.
- Sweep 0..255 back-to-back against a behavioural /10 and %10 model -> all 256 results match, with exactly 256 done pulses.
